// File: rtl/bsearch_ctrl.sv
// -----------------------------------------------------------------------------
// bsearch_ctrl
//   Binary-search sequencer for a sorted, ascending ram32x4-style memory with a
//   1-cycle registered read. Looks up a DATA_W-bit target and reports whether it
//   was found, where, and how many RAM probes the search used.
//
// Handshake (single rule for the whole block):
//   s is a level. Raising s in IDLE starts a search (target is sampled on that
//   edge). s must stay high until done; done is high only in DONE and stays high
//   while s is held. Dropping s in any state returns the block to IDLE on the
//   next edge. An abort leaves found/loc/probes at their partial values.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   reset_n    in   asynchronous, active-low reset
//   s          in   start/continue level
//   target     in   [DATA_W-1:0] value to search for
//   ram_addr   out  [ADDR_W-1:0] RAM read address, always equal to mid
//   ram_dout   in   [DATA_W-1:0] RAM read data (valid the cycle after address)
//   done       out  high in DONE only
//   found      out  match found in the last completed search
//   loc        out  [ADDR_W-1:0] address of the match, 0 when not found
//   probes     out  [2:0] compare cycles used by the last/current search
//   dbg_state  out  [1:0] current FSM state (0 IDLE, 1 READ, 2 CMP, 3 DONE)
// -----------------------------------------------------------------------------
module bsearch_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s,
    input  logic [DATA_W-1:0] target,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] loc,
    output logic [2:0]        probes,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    state_t            state;
    logic [ADDR_W-1:0] low;
    logic [ADDR_W-1:0] high;
    logic [DATA_W-1:0] tgt_q;

    // One extra bit on the sum so low+high never wraps before the halving.
    logic [ADDR_W:0]   sum;
    logic [ADDR_W-1:0] mid;

    always_comb begin
        sum = {1'b0, low} + {1'b0, high};
        mid = sum[ADDR_W:1];
    end

    assign ram_addr  = mid;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            low    <= '0;
            high   <= ADDR_MAX;
            tgt_q  <= '0;
            done   <= 1'b0;
            found  <= 1'b0;
            loc    <= '0;
            probes <= '0;
        end else begin
            case (state)
                IDLE: begin
                    low  <= '0;
                    high <= ADDR_MAX;
                    done <= 1'b0;
                    if (s) begin
                        tgt_q  <= target;
                        found  <= 1'b0;
                        loc    <= '0;
                        probes <= '0;
                        state  <= READ;
                    end
                end

                // The RAM registers ram_addr (= mid) on the edge leaving READ.
                READ: begin
                    if (!s) begin
                        low   <= '0;
                        high  <= ADDR_MAX;
                        state <= IDLE;
                    end else begin
                        state <= CMP;
                    end
                end

                CMP: begin
                    probes <= probes + 3'd1;
                    if (!s) begin
                        // Bounds go back to full range so ram_addr is the
                        // midpoint of the whole memory as soon as IDLE is entered.
                        low   <= '0;
                        high  <= ADDR_MAX;
                        state <= IDLE;
                    end else if (ram_dout == tgt_q) begin
                        found <= 1'b1;
                        loc   <= mid;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (ram_dout < tgt_q) begin
                        // mid == high means the window is exhausted; stepping
                        // low past high could also wrap at the top address.
                        if (mid == high) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            low   <= mid + 1'b1;
                            state <= READ;
                        end
                    end else begin
                        // Mirror case: guards high against underflow at 0.
                        if (mid == low) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            high  <= mid - 1'b1;
                            state <= READ;
                        end
                    end
                end

                DONE: begin
                    if (!s) begin
                        low   <= '0;
                        high  <= ADDR_MAX;
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
